// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Address layout: [29:5] tag, [4:2] index, [1:0] word offset.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    localparam int OFF_W   = 2;
    localparam int IDX_W   = 3;
    localparam int TAG_W   = 25;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;

    // Replace one 32-bit word of a block, leaving the other words untouched.
    function automatic logic [BLOCK_W-1:0] merge_word(
        input logic [BLOCK_W-1:0] blk,
        input logic [OFF_W-1:0]   off,
        input logic [WORD_W-1:0]  word
    );
        logic [BLOCK_W-1:0] res;
        res = blk;
        res[off*WORD_W +: WORD_W] = word;
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty bits (cleared by reset) plus tag/data arrays
// (not cleared), one synchronous write port and a combinational read port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_BITS   = IDX_W,
    parameter int TAG_BITS   = TAG_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IDX_BITS-1:0] idx_i,
    input  logic                we_i,
    input  logic                wr_dirty_i,
    input  logic [TAG_BITS-1:0] wr_tag_i,
    input  logic [BLOCK_W-1:0]  wr_data_i,
    output logic                valid_o,
    output logic                dirty_o,
    output logic [TAG_BITS-1:0] tag_o,
    output logic [BLOCK_W-1:0]  data_o
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

    // Status bits: reset wins over any write in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= wr_dirty_i;
        end
    end

    // Tag and data payload; a write coinciding with reset is dropped so an aborted fill leaves the line alone.
    always_ff @(posedge clk_i) begin
        if (rst_i && we_i) begin
            tag_q[idx_i]  <= wr_tag_i;
            data_q[idx_i] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: hit logic,
// miss FSM (IDLE/WRITEBACK/ALLOCATE) and the 128-bit memory-side handshake.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 proc_read,
    input  logic                 proc_write,
    input  logic [29:0]          proc_addr,
    input  logic [31:0]          proc_wdata,
    output logic [31:0]          proc_rdata,
    output logic                 proc_stall,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [27:0]          mem_addr,
    output logic [BLOCK_W-1:0]   mem_wdata,
    input  logic [BLOCK_W-1:0]   mem_rdata,
    input  logic                 mem_ready
);

    localparam int IDX_BITS = $clog2(NUM_BLOCKS);
    localparam int TAG_BITS = 30 - OFF_W - IDX_BITS;

    state_e                state_q;
    state_e                state_d;

    logic                  req_s;
    logic                  hit_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic [IDX_BITS-1:0]   idx_s;
    logic [OFF_W-1:0]      off_s;

    logic                  line_valid_s;
    logic                  line_dirty_s;
    logic [TAG_BITS-1:0]   line_tag_s;
    logic [BLOCK_W-1:0]    line_data_s;

    logic                  arr_we_s;
    logic                  arr_dirty_s;
    logic [BLOCK_W-1:0]    arr_data_s;
    logic [WORD_W-1:0]     rdata_s;

    assign tag_s = proc_addr[29 -: TAG_BITS];
    assign idx_s = proc_addr[OFF_W +: IDX_BITS];
    assign off_s = proc_addr[OFF_W-1:0];

    assign req_s = proc_read | proc_write;
    assign hit_s = line_valid_s && (line_tag_s == tag_s);

    dcache_array #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_BITS   (IDX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idx_i      (idx_s),
        .we_i       (arr_we_s),
        .wr_dirty_i (arr_dirty_s),
        .wr_tag_i   (tag_s),
        .wr_data_i  (arr_data_s),
        .valid_o    (line_valid_s),
        .dirty_o    (line_dirty_s),
        .tag_o      (line_tag_s),
        .data_o     (line_data_s)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and line-update control; a store wins when read and write are both asserted.
    always_comb begin
        state_d     = state_q;
        arr_we_s    = 1'b0;
        arr_dirty_s = 1'b0;
        arr_data_s  = line_data_s;
        case (state_q)
            ST_IDLE: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                end else if (hit_s) begin
                    if (proc_write) begin
                        arr_we_s    = 1'b1;
                        arr_dirty_s = 1'b1;
                        arr_data_s  = merge_word(line_data_s, off_s, proc_wdata);
                    end else begin
                        arr_we_s    = 1'b0;
                    end
                end else if (line_valid_s && line_dirty_s) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ready) begin
                    state_d = ST_ALLOCATE;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                if (mem_ready) begin
                    arr_we_s    = 1'b1;
                    arr_dirty_s = 1'b0;
                    arr_data_s  = mem_rdata;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_ALLOCATE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Addressed word of the indexed line.
    always_comb begin
        rdata_s = '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            rdata_s = (off_s == w[OFF_W-1:0]) ? line_data_s[w*WORD_W +: WORD_W] : rdata_s;
        end
    end

    assign proc_rdata = rdata_s;
    assign proc_stall = req_s && !((state_q == ST_IDLE) && hit_s);
    assign mem_write  = (state_q == ST_WRITEBACK);
    assign mem_read   = (state_q == ST_ALLOCATE);
    // The victim keeps its stored tag until the fill lands, so the writeback address stays stable.
    assign mem_addr   = (state_q == ST_WRITEBACK) ? {line_tag_s, idx_s} : proc_addr[29:OFF_W];
    assign mem_wdata  = line_data_s;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed and randomized bench for dcache_ctrl against a line-level cache
// and memory model kept in the bench.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int checks = 0;
    int errors = 0;

    bit           m_valid [8];
    bit           m_dirty [8];
    logic [24:0]  m_tag   [8];
    logic [31:0]  m_data  [8][4];
    logic [127:0] mem_blk [int];

    logic [31:0]  last_rdata;
    logic [27:0]  last_wb_addr;
    logic [127:0] last_wb_data;
    logic [27:0]  last_al_addr;

    dcache_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] fetch_blk(input int ba);
        logic [127:0] b;
        if (mem_blk.exists(ba)) begin
            b = mem_blk[ba];
        end else begin
            for (int w = 0; w < 4; w++) b[w*32 +: 32] = 32'h5A00_0000 ^ 32'(ba * 4 + w);
        end
        return b;
    endfunction

    function automatic logic [127:0] line_blk(input int i);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) b[w*32 +: 32] = m_data[i][w];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // One complete access, acting as the memory for any miss; lat = idle cycles before mem_ready.
    task automatic do_access(input bit rd, input bit wr, input logic [29:0] addr,
                             input logic [31:0] wd, input int lat);
        int           idx;
        int           off;
        int           ba;
        int           victim_ba;
        logic [24:0]  tg;
        logic [127:0] victim;
        logic [127:0] fill;
        bit           hit;
        idx = int'(addr / 30'd4) % 8;
        off = int'(addr) % 4;
        ba  = int'(addr / 30'd4);
        tg  = 25'(addr / 30'd32);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        @(negedge clk);
        if (!hit) begin
            check("miss_stall", proc_stall, 1);
            check("miss_idle_mem", {mem_read, mem_write}, 0);
            if (m_valid[idx] && m_dirty[idx]) begin
                victim_ba = int'(m_tag[idx]) * 8 + idx;
                victim    = line_blk(idx);
                tick();
                @(negedge clk);
                last_wb_addr = mem_addr;
                last_wb_data = mem_wdata;
                for (int c = 0; c <= lat; c++) begin
                    check("wb_mem_write", mem_write, 1);
                    check("wb_mem_read", mem_read, 0);
                    check("wb_addr", mem_addr, victim_ba);
                    check("wb_data", mem_wdata, victim);
                    check("wb_stall", proc_stall, 1);
                    if (c < lat) begin
                        tick();
                        @(negedge clk);
                    end
                end
                mem_ready = 1'b1;
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
                mem_blk[victim_ba] = victim;
            end else begin
                tick();
            end
            @(negedge clk);
            last_al_addr = mem_addr;
            for (int c = 0; c <= lat; c++) begin
                check("al_mem_read", mem_read, 1);
                check("al_mem_write", mem_write, 0);
                check("al_addr", mem_addr, ba);
                check("al_stall", proc_stall, 1);
                if (c < lat) begin
                    tick();
                    @(negedge clk);
                end
            end
            fill      = fetch_blk(ba);
            mem_rdata = fill;
            mem_ready = 1'b1;
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            for (int w = 0; w < 4; w++) m_data[idx][w] = fill[w*32 +: 32];
            @(negedge clk);
        end
        check("hit_stall", proc_stall, 0);
        check("hit_mem_idle", {mem_read, mem_write}, 0);
        if (!wr) check("hit_rdata", proc_rdata, m_data[idx][off]);
        last_rdata = proc_rdata;
        if (wr) begin
            m_data[idx][off] = wd;
            m_dirty[idx]     = 1'b1;
        end
        tick();
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    initial begin
        logic [127:0] blk4;
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_stall", proc_stall, 0);
        tick();

        // Cold read miss with a three-cycle memory.
        blk4 = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hAAAA_0000};
        mem_blk[4] = blk4;
        do_access(1'b1, 1'b0, 30'h0000010, 32'h0, 3);
        check("tp_fill_addr", last_al_addr, 28'h0000004);
        check("tp_fill_word0", last_rdata, 32'hAAAA_0000);

        // Store hit then load back.
        do_access(1'b0, 1'b1, 30'h0000011, 32'hDEAD_BEEF, 0);
        do_access(1'b1, 1'b0, 30'h0000011, 32'h0, 0);
        check("tp_store_load", last_rdata, 32'hDEAD_BEEF);

        // Conflict miss on a dirty line.
        do_access(1'b1, 1'b0, 30'h0000110, 32'h0, 2);
        check("tp_wb_addr", last_wb_addr, 28'h0000004);
        check("tp_wb_word1", last_wb_data[63:32], 32'hDEAD_BEEF);
        check("tp_al_addr", last_al_addr, 28'h0000044);

        // Read and write together on a hit behaves as a store.
        do_access(1'b1, 1'b1, 30'h0000112, 32'hCAFE_F00D, 0);
        do_access(1'b1, 1'b0, 30'h0000010, 32'h0, 1);
        check("tp_rw_wb_addr", last_wb_addr, 28'h0000044);
        check("tp_rw_wb_word2", last_wb_data[95:64], 32'hCAFE_F00D);
        check("tp_refetch_word1", last_rdata, 32'hAAAA_0000);
        do_access(1'b1, 1'b0, 30'h0000112, 32'h0, 0);
        check("tp_refetch_merged", last_rdata, 32'hCAFE_F00D);

        // Reset during ALLOCATE aborts the fill.
        proc_read = 1'b1;
        proc_addr = 30'h0000204;
        @(negedge clk);
        check("rstmid_stall", proc_stall, 1);
        tick();
        @(negedge clk);
        check("rstmid_alloc", mem_read, 1);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        proc_read = 1'b0;
        model_reset();
        @(negedge clk);
        check("rstmid_mem_read", mem_read, 0);
        check("rstmid_mem_write", mem_write, 0);
        check("rstmid_stall_idle", proc_stall, 0);
        tick();
        do_access(1'b1, 1'b0, 30'h0000204, 32'h0, 1);

        // mem_ready while idle is ignored.
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check("stray_ready_read", mem_read, 0);
        check("stray_ready_write", mem_write, 0);
        check("stray_ready_stall", proc_stall, 0);
        tick();

        // Slow memory: outputs hold for 20 cycles.
        do_access(1'b1, 1'b0, 30'h00003F8, 32'h0, 20);

        // Randomized traffic over a few conflicting tags.
        for (int n = 0; n < 250; n++) begin
            int          op;
            logic [29:0] a;
            a  = 30'($urandom_range(0, 3) * 32 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            op = $urandom_range(0, 3);
            do_access(op != 2, op >= 2, a, $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache sitting between the MEM stage and the slow off-chip data memory. Serves MEM-stage loads and stores, and returns load data to the MEM/WB pipeline register. Raises a stall that freezes the pipeline while a miss is serviced. Moves 128-bit blocks over a request/ready handshake on the memory side.

## Interface
- NUM_BLOCKS, 8: cache lines; power of two; index width = log2(NUM_BLOCKS).
- WORDS_PER_BLOCK, 4: fixed at 4; the memory bus is 128 bits.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- proc_read  in  1  load request from the MEM stage.
- proc_write  in  1  store request from the MEM stage.
- proc_addr  in  30  word address; [1:0] word offset, [4:2] index, [29:5] tag (25 bits).
- proc_wdata  in  32  store data.
- proc_rdata  out  32  load data; combinational from the selected line.
- proc_stall  out  1  pipeline hold; combinational.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block writeback request.
- mem_addr  out  28  block address, {tag, index}.
- mem_wdata  out  128  victim block; word 0 in [31:0].
- mem_rdata  in  128  fetched block; word 0 in [31:0].
- mem_ready  in  1  one-cycle pulse: the current memory transfer is complete.

## Operation
Per-line storage:
- valid (1 bit), dirty (1 bit), tag (25 bits), data (128 bits).

Request rules:
- A request is active when proc_read or proc_write is high.
- If both are high, the request is a write.
- hit = valid[index] && tag[index] == proc_addr[29:5].

FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: stay in IDLE; proc_stall=0.
- IDLE, read hit: proc_rdata = the addressed word in the same cycle; proc_stall=0.
- IDLE, write hit: at the edge, write proc_wdata into the addressed word and set dirty; proc_stall=0.
- IDLE, miss on a clean or invalid line: go to ALLOCATE.
- IDLE, miss on a valid dirty line: go to WRITEBACK.
- WRITEBACK: mem_write=1, mem_addr={stored tag, index}, mem_wdata = line data.
  - Hold until mem_ready, then go to ALLOCATE.
- ALLOCATE: mem_read=1, mem_addr=proc_addr[29:2].
  - On mem_ready: line data=mem_rdata, tag=proc_addr[29:5], valid=1, dirty=0; go to IDLE.
- On return to IDLE the request is still held by the frozen pipeline, so it is re-evaluated as a hit. A write is merged at that point and sets dirty.

Output rules:
- proc_stall = request active && !(state==IDLE && hit).
- mem_read and mem_write are decoded from the state only (Moore); they are never high together.
- proc_rdata is don't-care when there is no read hit; it is driven from the indexed line.

## Timing
- Reset (rst_i=0 at an edge): state=IDLE, all valid and dirty bits=0.
  - Outputs the following cycle: mem_read=0, mem_write=0, proc_stall=0 when no request.
  - Data and tag arrays are not cleared.
- Hit latency is 0 cycles: a load completes in the cycle it is presented.
- Clean miss: stall lasts from the request cycle until the edge where mem_ready is sampled in ALLOCATE, plus one IDLE cycle for the hit.
- Dirty miss adds the WRITEBACK phase ahead of the clean-miss sequence.
- Address and data stability:
  - mem_addr and mem_wdata are stable for the whole time mem_read or mem_write is high.
  - The request inputs are stable while proc_stall=1; the pipeline guarantees this.
- mem_ready outside WRITEBACK or ALLOCATE is ignored.
- WRITEBACK to ALLOCATE: mem_write falls and mem_read rises on the same edge. No idle cycle between them.
- Reset mid-miss aborts the miss: the line is not updated and the request lines drop on the next cycle. A partially written memory block is acceptable.

## Structure
- A shared package holds:
  - the state enum;
  - the TAG_W, IDX_W and OFF_W localparams;
  - the BLOCK_W=128 constant.
- One sub-module, dcache_array, holds the valid/dirty/tag/data storage with a synchronous write port and a combinational read port.
- The FSM and hit logic live in the top module.

## Test plan
- Reset, then read 0x0000010: miss. mem_read=1 and mem_addr=0x0000004. Return mem_rdata with word 0=0xAAAA0000 after 3 cycles. Then proc_rdata=0xAAAA0000 and proc_stall drops.
- Write 0xDEADBEEF to 0x0000011 after the previous fill: write hit with no stall. A following read of 0x0000011 returns 0xDEADBEEF with no stall.
- Read 0x0000110 (same index, different tag) while the line is dirty:
  - WRITEBACK first: mem_write=1, mem_addr=0x0000004, mem_wdata[63:32]=0xDEADBEEF.
  - Then ALLOCATE: mem_read=1, mem_addr=0x0000044.
- Assert proc_read and proc_write together on a hit: treated as a write, so dirty is set and the data is updated.
- Pulse rst_i low while in ALLOCATE: mem_read=0 on the next cycle. A re-issued read of the same address misses again (valid cleared).
- Hold mem_ready=0 for 20 cycles: mem_read, mem_addr and proc_stall stay constant throughout.
